// File: rtl/one_out_buffer_pkg.sv
// Shared constants and types for the one adder result buffer.
// Imported by one_out_fifo, one_out_buffer and the one wrapper.
package one_out_buffer_pkg;

    localparam int WIDTH_DEFAULT   = 32;
    localparam int LATENCY_DEFAULT = 2;
    localparam int DEPTH_DEFAULT   = 4;

    typedef logic [WIDTH_DEFAULT-1:0] one_result_t;

endpackage

// File: rtl/one_out_fifo.sv
// Circular-buffer FIFO with stored count; storage cleared on reset.
// Ports: clk, rst, wr_en/wr_data, rd_en/rd_data, empty, full.
module one_out_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_wr, do_rd;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign rd_data = mem_q[rptr_q];

    // The writer guarantees space; a write while full is only
    // issued alongside a pop, which frees the slot.
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_wr) begin
            mem_d[wptr_q] = wr_data;
            wptr_d = (wptr_q == LAST) ? '0 : wptr_q + AW'(1);
        end
        if (do_rd) begin
            rptr_d = (rptr_q == LAST) ? '0 : rptr_q + AW'(1);
        end
        unique case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/one_out_buffer.sv
// Result flow control for the one adder: valid delay line, credit
// counter and output FIFO with valid/ready towards the consumer.
// Ports: clk, rst, issue_valid, issue_ok, pipe_out, out_data,
// out_valid, out_ready, occupancy; err when ONE_OUT_BUFFER_ERR_EN.
module one_out_buffer
    import one_out_buffer_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int LATENCY = LATENCY_DEFAULT,
    parameter int DEPTH   = DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    output logic                       issue_ok,
    input  logic [WIDTH-1:0]           pipe_out,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef ONE_OUT_BUFFER_ERR_EN
    ,
    output logic                       err
`endif
);

    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [OW-1:0]      occ_q, occ_d;
    logic               accept, pop, res_valid;
    logic               fifo_empty, fifo_full, fifo_wr;

    // Credits cover in-flight and stored results, so a free credit
    // always means a free FIFO slot when the result lands.
    assign issue_ok  = ~rst & (occ_q < DEPTH_C);
    assign accept    = issue_valid & issue_ok;
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign res_valid = vld_q[LATENCY-1];
    assign fifo_wr   = res_valid & (~fifo_full | pop);
    assign occupancy = occ_q;

    always_comb begin
        vld_d[0] = accept;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_comb begin
        unique case ({accept, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            occ_q <= '0;
        end else begin
            vld_q <= vld_d;
            occ_q <= occ_d;
        end
    end

    one_out_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (pipe_out),
        .rd_en   (pop),
        .rd_data (out_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

`ifdef ONE_OUT_BUFFER_ERR_EN
    logic err_q, err_d;

    assign err_d = err_q | (issue_valid & ~issue_ok);
    assign err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    a_issue_credit: assert property (
        @(posedge clk) disable iff (rst)
        !(issue_valid && !issue_ok)
    ) else $warning("issue_valid without credit");
`endif

endmodule

// File: tb/tb_one_out_buffer.sv
// Scoreboard bench for one_out_buffer with a behavioural adder pipe.
// Issues push expected sums; a monitor checks every output cycle.
module tb_one_out_buffer;
    import one_out_buffer_pkg::*;

    localparam int LAT = 2;
    localparam int DEP = 4;
    localparam int QSZ = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ok;
    logic [31:0] x, y;
    logic [31:0] p1, p2;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  occupancy;
`ifdef ONE_OUT_BUFFER_ERR_EN
    logic        err;
`endif

    one_out_buffer #(
        .WIDTH   (32),
        .LATENCY (LAT),
        .DEPTH   (DEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ok    (issue_ok),
        .pipe_out    (p2),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .occupancy   (occupancy)
`ifdef ONE_OUT_BUFFER_ERR_EN
        ,
        .err         (err)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in for the one adder: two unreset stages, no stall.
    always @(posedge clk) begin
        p1 <= x + y;
        p2 <= p1;
    end

    // Scoreboard: expected result and the first cycle it is visible.
    one_result_t exp_data [QSZ];
    int          exp_av   [QSZ];
    int          wr_n = 0;
    int          rd_n = 0;
    int          cyc  = 0;
    logic        ok_s = 1'b0;
    logic        err_m = 1'b0;
    logic        prev_rst = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h",
                     nm, cyc, act, exp);
        end
    endtask

    // Issue side: an accepted issue at cycle c is visible at c+LAT+1.
    always @(posedge clk) begin
        if (!rst && issue_valid && ok_s) begin
            exp_data[wr_n % QSZ] <= x + y;
            exp_av[wr_n % QSZ]   <= cyc + LAT;
            wr_n <= wr_n + 1;
        end
    end

    // Monitor: compare outputs mid-cycle, pop on handshake.
    always @(negedge clk) begin
        int   now;
        int   occ_m;
        logic ok_m;
        logic valid_m;
        now     = cyc;
        occ_m   = wr_n - rd_n;
        ok_m    = !rst && (occ_m < DEP);
        valid_m = (occ_m > 0) && (exp_av[rd_n % QSZ] <= now);
        chk("issue_ok", 64'(issue_ok), 64'(ok_m));
        chk("out_valid", 64'(out_valid), 64'(valid_m));
        chk("occupancy", 64'(occupancy), 64'(occ_m));
        if (valid_m) begin
            chk("out_data", 64'(out_data), 64'(exp_data[rd_n % QSZ]));
        end else if (prev_rst) begin
            chk("out_data_rst", 64'(out_data), 64'd0);
        end
`ifdef ONE_OUT_BUFFER_ERR_EN
        chk("err", 64'(err), 64'(err_m));
        err_m <= rst ? 1'b0 : (err_m | (issue_valid & ~ok_m));
`endif
        if (rst) begin
            rd_n <= wr_n;
        end else if (valid_m && out_ready) begin
            rd_n <= rd_n + 1;
        end
        ok_s     <= ok_m;
        prev_rst <= rst;
        cyc      <= now + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_stalled(input int n);
        out_ready = 1'b0;
        repeat (n) begin
            issue_valid = issue_ok;
            x = $urandom;
            y = $urandom;
            step(1);
        end
        issue_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0;
        x = '0;
        y = '0;
        out_ready = 1'b1;
        step(3);
        rst = 1'b0;

        // single issue 5+7
        x = 32'd5;
        y = 32'd7;
        issue_valid = 1'b1;
        step(1);
        issue_valid = 1'b0;
        step(6);

        // back-to-back stream of i+1
        for (int i = 0; i < 20; i++) begin
            x = i;
            y = 32'd1;
            issue_valid = 1'b1;
            step(1);
        end
        issue_valid = 1'b0;
        step(6);

        // backpressure, then drain
        fill_stalled(10);
        step(3);
        out_ready = 1'b1;
        step(8);

        // full FIFO, then pops racing fresh captures
        fill_stalled(8);
        for (int i = 0; i < 24; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            issue_valid = issue_ok;
            x = $urandom;
            y = $urandom;
            step(1);
        end
        issue_valid = 1'b0;
        out_ready = 1'b1;
        step(8);

        // reset with results in flight
        for (int i = 0; i < 3; i++) begin
            x = 32'h100 + i;
            y = 32'h10;
            issue_valid = 1'b1;
            step(1);
        end
        issue_valid = 1'b0;
        step(1);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(6);

        // protocol violation while out of credit
        fill_stalled(8);
        x = 32'd100;
        y = 32'd200;
        issue_valid = 1'b1;
        step(1);
        issue_valid = 1'b0;
        step(2);
        out_ready = 1'b1;
        step(8);

        // randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            logic r;
            r = ($urandom_range(0, 63) == 0);
            rst = r;
            out_ready = ($urandom_range(0, 2) != 0);
            issue_valid = !r && issue_ok &&
                          ($urandom_range(0, 3) != 0);
            x = $urandom;
            y = $urandom;
            step(1);
        end
        rst = 1'b0;
        issue_valid = 1'b0;
        out_ready = 1'b1;
        step(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
